fnd_scan_controller: RTL and testbench
======================================

// Module: fnd_scan_controller
// PURPOSE
//  Time-multiplexed scan controller for the 4-digit common-anode FND on the counter board.
//  Takes four packed BCD digits and a decimal-point mask, then sequences one digit at a time:
//  com select, segment pattern, ghost-blanking interval and leading-zero suppression.
//  Sits between the 0..9999 counter datapath and the board pins.
// PARAMETERS
//  SCAN_DIV   100_000  clocks per digit slot (1 kHz per digit at 100 MHz); must be > BLANK_CYC+1
//  BLANK_CYC  16       clocks at the start of each slot with every com off (anti-ghosting)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  reset      in   1   synchronous, active-high
//  en         in   1   1 = scan; 0 = display dark, scan state held at reset values
//  bcd_in     in   16  {d3,d2,d1,d0}, 4 bits each, d3 = thousands; 4'hA..4'hF show hex glyphs
//  dp_in      in   4   per-digit decimal point, bit i -> digit i, 1 = lit
//  lzb_en     in   1   1 = suppress leading zeros on d3..d1 (d0 always shown)
//  fnd_com    out  4   digit enable, active-low, one-hot-low while driving, 4'hF otherwise
//  fnd_data   out  8   {dp,g,f,e,d,c,b,a}, active-low; 8'hFF = dark
// BEHAVIOUR
//  Reset (or en=0): fnd_com=4'hF, fnd_data=8'hFF, presc=0, dig_idx=0, state=BLANK, snapshot=0.
//  Prescaler: presc counts 0..SCAN_DIV-1 and wraps; slot_end = (presc==SCAN_DIV-1).
//  FSM, 2 states:
//   BLANK: com off, data 8'hFF; blank_cnt counts 0..BLANK_CYC-1, then -> DRIVE.
//   DRIVE: com[dig_idx]=0, data = glyph(digit) with bit7 = ~dp; held until slot_end.
//   slot_end in either state: dig_idx <= dig_idx+1 (3 wraps to 0), state <= BLANK, blank_cnt <= 0.
//  Slot length is exactly SCAN_DIV clocks; full frame is 4*SCAN_DIV clocks.
//  Snapshot: bcd_in/dp_in/lzb_en sampled into shadow regs when dig_idx enters 0
//   (3->0 wrap) and on the first cycle en=1 after reset or en=0. Mid-frame input changes
//   never tear a frame.
//  Leading-zero blank: digit i (i=3..1) is dark (data 8'hFF, com still asserted) when
//   lzb_en_snap=1 and snap digits i..3 are all 4'h0. dp still lights on a blanked digit.
//  Glyph table (active-low, bit7=1): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90
//   A:88 b:83 C:C6 d:A1 E:86 F:8E; dp clears bit7.
//  Outputs are registered: fnd_com/fnd_data reflect the state/index of the previous clock
//   (1-cycle latency). fnd_com and fnd_data change on the same edge; no cycle with the
//   new com and the old data.
//  en falling: the next edge forces dark outputs and reset state. en rising: the frame
//   restarts at digit 0, BLANK.
//  reset mid-slot: same as power-up; the first DRIVE on digit 0 comes BLANK_CYC+1 clocks
//   after reset deasserts.
//  Never more than one com low at a time, including across the wrap.
// STRUCTURE
//  fnd_pkg: FSM state enum {BLANK, DRIVE}, FND_DARK=8'hFF, COM_OFF=4'hF, glyph constants.
//  Sub-module fnd_seg_lut: combinational 4-bit -> 7-segment active-low lookup, instantiated
//   once on the muxed snapshot digit; dp and blanking are applied in this block.
//  Counters: presc $clog2(SCAN_DIV) bits, blank_cnt $clog2(BLANK_CYC+1) bits, dig_idx 2 bits.
// TESTING (bench with SCAN_DIV=8, BLANK_CYC=2)
//  1 reset held 3 clk, en=1, bcd_in=16'h1234 -> during reset com=F/data=FF; digit0: 2 clk dark,
//    then com=E data=99 for 6 clk; com=D B0, com=B A4, com=7 F9; frame = 32 clk.
//  2 bcd_in=16'h0042, lzb_en=1 -> d3,d2 slots: com asserted, data=FF; d1=99, d0=A4;
//    lzb_en=0 -> d3=C0, d2=C0.
//  3 dp_in=4'b0100, bcd_in=16'h0800 -> digit2 data=00 (8 with dp); the other digits have bit7=1.
//  4 bcd_in changed from 16'h1111 to 16'h2222 while digit1 is driven -> digits 1..3 still
//    show F9; next frame shows A4.
//  5 en=0 mid-DRIVE -> next clk com=F, data=FF; en=1 -> restart at digit0 BLANK (2 clk dark).
//  6 reset pulsed 1 clk mid-digit2 -> the following clk is dark, digit0 DRIVE after 3 clk;
//    assert $onehot0(~fnd_com) every cycle throughout.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit common-anode FND scan controller.
package fnd_pkg;

  // Scan FSM: every digit slot opens dark, then drives its digit.
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } fnd_state_e;

  // Pin-level idle values (active-low board pins).
  localparam logic [7:0] FND_DARK = 8'hFF;
  localparam logic [3:0] COM_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // Segment glyphs {g,f,e,d,c,b,a}, active-low; decimal point handled separately.
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Frame-stable copy of the display inputs.
  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        lzb_en;
  } fnd_snap_t;

  localparam fnd_snap_t SNAP_CLEAR = '{bcd: 16'h0000, dp: 4'h0, lzb_en: 1'b0};

  // One-hot-low common select for a digit index.
  function automatic logic [3:0] com_select(input logic [1:0] idx);
    logic [3:0] com;
    case (idx)
      2'd0:    com = 4'hE;
      2'd1:    com = 4'hD;
      2'd2:    com = 4'hB;
      2'd3:    com = 4'h7;
      default: com = COM_OFF;
    endcase
    return com;
  endfunction

  // True when digit idx and every more significant digit are zero.
  // Digit 0 is never considered a leading zero.
  function automatic logic is_lead_zero(input logic [15:0] bcd, input logic [1:0] idx);
    logic lz;
    case (idx)
      2'd3:    lz = (bcd[15:12] == 4'h0);
      2'd2:    lz = (bcd[15:8] == 8'h00);
      2'd1:    lz = (bcd[15:4] == 12'h000);
      default: lz = 1'b0;
    endcase
    return lz;
  endfunction

endpackage

// File: rtl/fnd_seg_lut.sv
// Combinational digit-to-segment lookup with decimal point and blanking applied.
module fnd_seg_lut
  import fnd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph_s;

  // Map the 4-bit digit to its active-low glyph (hex digits included).
  always_comb begin
    glyph_s = SEG_OFF;
    case (digit_i)
      4'h0:    glyph_s = GLYPH_0;
      4'h1:    glyph_s = GLYPH_1;
      4'h2:    glyph_s = GLYPH_2;
      4'h3:    glyph_s = GLYPH_3;
      4'h4:    glyph_s = GLYPH_4;
      4'h5:    glyph_s = GLYPH_5;
      4'h6:    glyph_s = GLYPH_6;
      4'h7:    glyph_s = GLYPH_7;
      4'h8:    glyph_s = GLYPH_8;
      4'h9:    glyph_s = GLYPH_9;
      4'hA:    glyph_s = GLYPH_A;
      4'hB:    glyph_s = GLYPH_B;
      4'hC:    glyph_s = GLYPH_C;
      4'hD:    glyph_s = GLYPH_D;
      4'hE:    glyph_s = GLYPH_E;
      4'hF:    glyph_s = GLYPH_F;
      default: glyph_s = SEG_OFF;
    endcase
  end

  // Blanked digits keep their decimal point; dp is active-low on bit 7.
  always_comb begin
    seg_o = FND_DARK;
    if (blank_i) begin
      seg_o = {~dp_i, SEG_OFF};
    end else begin
      seg_o = {~dp_i, glyph_s};
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-anode FND.
// Each digit slot is SCAN_DIV clocks: BLANK_CYC dark clocks, then the digit is driven.
// Inputs are snapshotted once per frame so a frame never mixes old and new values.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);

  fnd_state_e     state_q,     state_d;
  logic [PW-1:0]  presc_q,     presc_d;
  logic [BW-1:0]  blank_cnt_q, blank_cnt_d;
  logic [1:0]     dig_idx_q,   dig_idx_d;
  logic           run_q,       run_d;
  fnd_snap_t      snap_q,      snap_d;
  logic [3:0]     com_q,       com_d;
  logic [7:0]     data_q,      data_d;

  logic           slot_end_s;
  logic [3:0]     digit_s;
  logic           dp_s;
  logic           blank_s;
  logic [7:0]     seg_s;

  // Select the snapshot digit for the current slot and decide leading-zero blanking.
  always_comb begin
    slot_end_s = (presc_q == PRESC_LAST);
    digit_s    = snap_q.bcd[{dig_idx_q, 2'b00} +: 4];
    dp_s       = snap_q.dp[dig_idx_q];
    blank_s    = snap_q.lzb_en & is_lead_zero(snap_q.bcd, dig_idx_q);
  end

  fnd_seg_lut u_seg_lut (
    .digit_i (digit_s),
    .dp_i    (dp_s),
    .blank_i (blank_s),
    .seg_o   (seg_s)
  );

  // Next-state logic: prescaler, slot sequencing, FSM, snapshot and pin values.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    blank_cnt_d = blank_cnt_q;
    dig_idx_d   = dig_idx_q;
    run_d       = run_q;
    snap_d      = snap_q;
    com_d       = COM_OFF;
    data_d      = FND_DARK;

    if (!en) begin
      // Disabled: hold everything at its reset value and keep the pins dark.
      state_d     = BLANK;
      presc_d     = '0;
      blank_cnt_d = '0;
      dig_idx_d   = 2'd0;
      run_d       = 1'b0;
      snap_d      = SNAP_CLEAR;
    end else begin
      run_d = 1'b1;

      // First enabled cycle after reset/disable: capture the frame inputs.
      if (!run_q) begin
        snap_d = '{bcd: bcd_in, dp: dp_in, lzb_en: lzb_en};
      end else begin
        snap_d = snap_q;
      end

      if (slot_end_s) begin
        presc_d     = '0;
        dig_idx_d   = dig_idx_q + 2'd1;
        state_d     = BLANK;
        blank_cnt_d = '0;
        // Wrapping back to digit 0 starts a new frame with fresh inputs.
        if (dig_idx_q == 2'd3) begin
          snap_d = '{bcd: bcd_in, dp: dp_in, lzb_en: lzb_en};
        end else begin
          snap_d = snap_d;
        end
      end else begin
        presc_d = presc_q + PW'(1);
        case (state_q)
          BLANK: begin
            if (blank_cnt_q == BLANK_LAST) begin
              state_d     = DRIVE;
              blank_cnt_d = '0;
            end else begin
              blank_cnt_d = blank_cnt_q + BW'(1);
            end
          end
          DRIVE: begin
            state_d = DRIVE;
          end
          default: begin
            state_d     = BLANK;
            blank_cnt_d = '0;
          end
        endcase
      end

      // Pins follow the state of this cycle, so com and data switch together.
      if (state_q == DRIVE) begin
        com_d  = com_select(dig_idx_q);
        data_d = seg_s;
      end else begin
        com_d  = COM_OFF;
        data_d = FND_DARK;
      end
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BLANK;
      presc_q     <= '0;
      blank_cnt_q <= '0;
      dig_idx_q   <= 2'd0;
      run_q       <= 1'b0;
      snap_q      <= SNAP_CLEAR;
      com_q       <= COM_OFF;
      data_q      <= FND_DARK;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      blank_cnt_q <= blank_cnt_d;
      dig_idx_q   <= dig_idx_d;
      run_q       <= run_d;
      snap_q      <= snap_d;
      com_q       <= com_d;
      data_q      <= data_d;
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with a small scan geometry.
module tb_fnd_scan_controller;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lzb_en;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;

  int total = 0;
  int bad   = 0;

  fnd_scan_controller #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .lzb_en   (lzb_en),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  always #5 clk = ~clk;

  // Behavioural model: t counts running cycles since the last reset/disable.
  logic [7:0]  glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          t = 0;
  int          m_slot;
  int          m_ph;
  logic [3:0]  m_dig;
  logic [15:0] m_bcd = 16'h0000;
  logic [3:0]  m_dp  = 4'h0;
  logic        m_lzb = 1'b0;
  logic [3:0]  exp_com  = 4'hF;
  logic [7:0]  exp_data = 8'hFF;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset || !en) begin
      exp_com     = 4'hF;
      exp_data    = 8'hFF;
      t           = 0;
      m_bcd       = 16'h0000;
      m_dp        = 4'h0;
      m_lzb       = 1'b0;
      model_valid = 1'b1;
    end else begin
      m_ph   = t % SD;
      m_slot = (t / SD) % 4;
      if (m_ph >= BC) begin
        m_dig    = 4'(m_bcd >> (4 * m_slot));
        exp_com  = ~(4'b0001 << m_slot);
        exp_data = glyph_tab[m_dig];
        if (m_lzb && m_slot > 0 && (m_bcd >> (4 * m_slot)) == 16'h0000)
          exp_data = 8'hFF;
        if (m_dp[m_slot])
          exp_data[7] = 1'b0;
      end else begin
        exp_com  = 4'hF;
        exp_data = 8'hFF;
      end
      if (t == 0 || (t % (4 * SD)) == (4 * SD - 1)) begin
        m_bcd = bcd_in;
        m_dp  = dp_in;
        m_lzb = lzb_en;
      end
      t = t + 1;
    end
  end

  // Advance n cycles, checking DUT against the model at every falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (model_valid) begin
        total++;
        if (fnd_com !== exp_com || fnd_data !== exp_data) begin
          bad++;
          $display("FAIL model_cmp @%0t: got com=%h data=%h, want com=%h data=%h",
                   $time, fnd_com, fnd_data, exp_com, exp_data);
        end
        total++;
        if (!$onehot0(~fnd_com)) begin
          bad++;
          $display("FAIL onehot_com @%0t: got com=%h, want at most one low bit", $time, fnd_com);
        end
      end
    end
  endtask

  // Hand-computed expectation checked against both the DUT and the model.
  task automatic lit(input string name, input logic [3:0] c, input logic [7:0] d);
    total++;
    if (fnd_com !== c || fnd_data !== d) begin
      bad++;
      $display("FAIL %s: got com=%h data=%h, want com=%h data=%h", name, fnd_com, fnd_data, c, d);
    end
    total++;
    if (exp_com !== c || exp_data !== d) begin
      bad++;
      $display("FAIL %s_model: got com=%h data=%h, want com=%h data=%h", name, exp_com, exp_data, c, d);
    end
  endtask

  task automatic restart();
    en = 1'b0;
    step(1);
    en = 1'b1;
  endtask

  // Restart a frame and check the driven value of each digit slot.
  task automatic check_frame(input string name, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    restart();
    step(3);  lit({name, "_d0"}, 4'hE, d0);
    step(8);  lit({name, "_d1"}, 4'hD, d1);
    step(8);  lit({name, "_d2"}, 4'hB, d2);
    step(8);  lit({name, "_d3"}, 4'h7, d3);
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    bcd_in = 16'h1234;
    dp_in  = 4'h0;
    lzb_en = 1'b0;

    // 1: reset, then a full frame of 1234.
    step(3);  lit("in_reset", 4'hF, 8'hFF);
    reset = 1'b0;
    step(1);  lit("blank0_a", 4'hF, 8'hFF);
    step(1);  lit("blank0_b", 4'hF, 8'hFF);
    step(1);  lit("d0_first", 4'hE, 8'h99);
    step(5);  lit("d0_last", 4'hE, 8'h99);
    step(1);  lit("blank1", 4'hF, 8'hFF);
    step(2);  lit("d1", 4'hD, 8'hB0);
    step(8);  lit("d2", 4'hB, 8'hA4);
    step(8);  lit("d3", 4'h7, 8'hF9);
    step(8);  lit("d0_frame2", 4'hE, 8'h99);

    // 2: leading-zero blanking on and off.
    bcd_in = 16'h0042; lzb_en = 1'b1;
    check_frame("lzb_on", 8'hA4, 8'h99, 8'hFF, 8'hFF);
    lzb_en = 1'b0;
    check_frame("lzb_off", 8'hA4, 8'h99, 8'hC0, 8'hC0);

    // 3: decimal point on digit 2.
    dp_in = 4'b0100; bcd_in = 16'h0800;
    check_frame("dp", 8'hC0, 8'hC0, 8'h00, 8'hC0);
    dp_in = 4'h0;

    // 4: mid-frame input change does not tear the frame.
    bcd_in = 16'h1111;
    restart();
    step(3);  lit("tear_d0", 4'hE, 8'hF9);
    step(8);  lit("tear_d1", 4'hD, 8'hF9);
    bcd_in = 16'h2222;
    step(8);  lit("tear_d2", 4'hB, 8'hF9);
    step(8);  lit("tear_d3", 4'h7, 8'hF9);
    step(8);  lit("tear_next", 4'hE, 8'hA4);

    // 5: en dropped mid-DRIVE, then restored.
    bcd_in = 16'h1234;
    restart();
    step(4);  lit("en_drive", 4'hE, 8'h99);
    en = 1'b0;
    step(1);  lit("en_off_a", 4'hF, 8'hFF);
    step(1);  lit("en_off_b", 4'hF, 8'hFF);
    en = 1'b1;
    step(2);  lit("en_on_blank", 4'hF, 8'hFF);
    step(1);  lit("en_on_d0", 4'hE, 8'h99);

    // 6: one-clock reset pulse in the middle of digit 2.
    restart();
    step(20); lit("rst_mid_d2", 4'hB, 8'hA4);
    reset = 1'b1;
    step(1);  lit("rst_dark", 4'hF, 8'hFF);
    reset = 1'b0;
    step(2);  lit("rst_blank", 4'hF, 8'hFF);
    step(1);  lit("rst_d0", 4'hE, 8'h99);

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bcd_in = 16'($urandom);
      if ($urandom_range(0, 39) == 0) dp_in  = 4'($urandom);
      if ($urandom_range(0, 39) == 0) lzb_en = 1'($urandom);
      en    = ($urandom_range(0, 399) != 0);
      reset = ($urandom_range(0, 599) == 0);
      step(1);
    end
    reset = 1'b0;
    en    = 1'b1;
    step(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
